// File: rtl/ibex_xif_icache_ram_arb.sv
// rtl/ibex_xif_icache_ram_arb.sv - single-port tag/data RAM arbiter for the icache
// Serialises invalidation sweep, ECC scrub, fill writes and lookup reads: one RAM op per cycle.
module ibex_xif_icache_ram_arb #(
  parameter int unsigned NumWays = 2,
  parameter int unsigned IndexW  = 8,
  parameter int unsigned TagW    = 22,
  parameter int unsigned LineW   = 64
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               inval_req_i,
  output logic               inval_busy_o,
  input  logic               lookup_req_i,
  input  logic [IndexW-1:0]  lookup_addr_i,
  output logic               lookup_gnt_o,
  output logic               lookup_rvalid_o,
  input  logic               fill_req_i,
  input  logic [IndexW-1:0]  fill_addr_i,
  input  logic [NumWays-1:0] fill_way_i,
  input  logic [TagW-1:0]    fill_tag_i,
  input  logic [LineW-1:0]   fill_data_i,
  output logic               fill_gnt_o,
  input  logic               ecc_err_i,
  output logic [NumWays-1:0] tag_req_o,
  output logic [NumWays-1:0] data_req_o,
  output logic               tag_write_o,
  output logic               data_write_o,
  output logic [IndexW-1:0]  tag_addr_o,
  output logic [IndexW-1:0]  data_addr_o,
  output logic [TagW-1:0]    tag_wdata_o,
  output logic [LineW-1:0]   data_wdata_o
);

  typedef enum logic [1:0] {SWEEP, IDLE, ECC_INV} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [IndexW-1:0] r_cnt;
  logic [1:0]        r_starve;
  logic              r_rvalid;
  logic [IndexW-1:0] r_raddr;
  logic              r_ecc_pend;
  logic [IndexW-1:0] r_ecc_addr;
  logic              w_lookup_gnt;
  logic              w_fill_gnt;
  logic              w_ecc_set;

  always_comb begin
    w_state_next = r_state;
    w_lookup_gnt = 1'b0;
    w_fill_gnt   = 1'b0;
    w_ecc_set    = 1'b0;
    inval_busy_o = 1'b0;
    tag_req_o    = '0;
    data_req_o   = '0;
    tag_write_o  = 1'b0;
    data_write_o = 1'b0;
    tag_addr_o   = '0;
    data_addr_o  = '0;
    tag_wdata_o  = '0;
    data_wdata_o = '0;
    case (r_state)
      SWEEP: begin
        inval_busy_o = 1'b1;
        tag_req_o    = '1;
        tag_write_o  = 1'b1;
        tag_addr_o   = r_cnt;
        if (r_cnt == '1) w_state_next = IDLE;
      end
      IDLE: begin
        if (inval_req_i) begin
          w_state_next = SWEEP;
        end else if (r_rvalid && ecc_err_i) begin
          // A detected error outranks everything else; no new read is issued behind it.
          w_ecc_set    = 1'b1;
          w_state_next = ECC_INV;
        end else if (fill_req_i && !(lookup_req_i && r_starve == 2'd3)) begin
          w_fill_gnt   = 1'b1;
          tag_req_o    = fill_way_i;
          data_req_o   = fill_way_i;
          tag_write_o  = 1'b1;
          data_write_o = 1'b1;
          tag_addr_o   = fill_addr_i;
          data_addr_o  = fill_addr_i;
          tag_wdata_o  = fill_tag_i;
          data_wdata_o = fill_data_i;
        end else if (lookup_req_i) begin
          w_lookup_gnt = 1'b1;
          tag_req_o    = '1;
          data_req_o   = '1;
          tag_addr_o   = lookup_addr_i;
          data_addr_o  = lookup_addr_i;
        end
      end
      ECC_INV: begin
        tag_req_o    = {NumWays{r_ecc_pend}};
        tag_write_o  = r_ecc_pend;
        tag_addr_o   = r_ecc_addr;
        w_state_next = IDLE;
      end
      default: w_state_next = SWEEP;
    endcase
    if (rst_i) begin
      w_state_next = SWEEP;
      w_lookup_gnt = 1'b0;
      w_fill_gnt   = 1'b0;
      w_ecc_set    = 1'b0;
      inval_busy_o = 1'b1;
      tag_req_o    = '0;
      data_req_o   = '0;
      tag_write_o  = 1'b0;
      data_write_o = 1'b0;
      tag_addr_o   = '0;
      data_addr_o  = '0;
      tag_wdata_o  = '0;
      data_wdata_o = '0;
    end
  end

  assign lookup_gnt_o    = w_lookup_gnt;
  assign fill_gnt_o      = w_fill_gnt;
  assign lookup_rvalid_o = r_rvalid & ~rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= SWEEP;
      r_cnt      <= '0;
      r_starve   <= '0;
      r_rvalid   <= 1'b0;
      r_raddr    <= '0;
      r_ecc_pend <= 1'b0;
      r_ecc_addr <= '0;
    end else begin
      r_state  <= w_state_next;
      // Counter idles at 0 so a new sweep always starts from index 0.
      r_cnt    <= (r_state == SWEEP) ? r_cnt + 1'b1 : '0;
      r_rvalid <= w_lookup_gnt;
      if (w_lookup_gnt) r_raddr <= lookup_addr_i;
      if (w_lookup_gnt) r_starve <= '0;
      else if (w_fill_gnt && lookup_req_i) r_starve <= r_starve + 2'd1;
      if (w_ecc_set) begin
        r_ecc_pend <= 1'b1;
        r_ecc_addr <= r_raddr;
      end else if (r_state == ECC_INV) begin
        r_ecc_pend <= 1'b0;
      end
    end
  end

endmodule
